width_change_16to8: RTL and testbench

//   Downstream companion of the 8->16 packer: takes packed 16-bit words (valid-only, no backpressure)
//   and re-serialises them into 8-bit bytes on a valid/ready interface, MSB byte first.
//   A DEPTH-word FIFO absorbs output stalls; words that arrive while full are dropped and flagged.

---
 rtl/width_change_16to8.sv | 105 ++++++++++
 tb/tb_width_change_16to8.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/width_change_16to8.sv
`timescale 1ns/1ps
// Purpose: re-serialise packed AWIDTH-bit words into BWIDTH-bit bytes, MSB byte first, via a DEPTH-word FIFO.
// Latency: a word written at edge N presents its first byte (b_vld=1) in the cycle after edge N.
// Backpressure: b_rdy low stalls output bytes stably; input words arriving while full without a pop are dropped (sticky ovf).
module width_change_16to8 #(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_vld,
    input  logic [AWIDTH-1:0] a,
    output logic              b_vld,
    output logic [BWIDTH-1:0] b,
    input  logic              b_rdy,
    output logic              full,
    output logic              ovf
);

    localparam int CNT_MAX = AWIDTH / BWIDTH;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PW      = $clog2(DEPTH);
    localparam int NW      = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(DEPTH);

    logic [AWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]     count_q,  count_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic              ovf_q,    ovf_d;

    logic              xfer;
    logic              pop;
    logic              push;
    logic              drop;
    logic [AWIDTH-1:0] head_shift;

    // Status and output byte selection, all derived from registered state (no write bypass).
    always_comb begin
        b_vld      = (count_q != '0);
        full       = (count_q == DEPTH_N);
        ovf        = ovf_q;
        head_shift = mem_q[rd_ptr_q] << (int'(cnt_q) * BWIDTH);
        b          = b_vld ? head_shift[AWIDTH-1 -: BWIDTH] : '0;
    end

    // Next-state: byte index, pointers, occupancy and sticky overflow.
    always_comb begin
        xfer     = b_vld && b_rdy;
        pop      = xfer && (cnt_q == CNT_LAST);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push     = a_vld && (!full || pop);
        drop     = a_vld && full && !pop;

        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q || drop;

        if (xfer) begin
            cnt_d = pop ? '0 : cnt_q + CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + NW'(1);
        end else if (pop && !push) begin
            count_d = count_q - NW'(1);
        end
    end

    // Control state register; reset discards any stored or partially sent word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Word storage; contents are only meaningful while counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= a;
        end
    end

endmodule

// File: tb/tb_width_change_16to8.sv
`timescale 1ns/1ps
module tb_width_change_16to8;

    logic        clk;
    logic        rst_n;
    logic        a_vld;
    logic [15:0] a;
    logic        b_vld;
    logic [7:0]  b;
    logic        b_rdy;
    logic        full;
    logic        ovf;

    int          checks;
    int          failures;
    logic [7:0]  exp_q[$];

    width_change_16to8 #(.AWIDTH(16), .BWIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_vld (a_vld),
        .a     (a),
        .b_vld (b_vld),
        .b     (b),
        .b_rdy (b_rdy),
        .full  (full),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, advance past the next rising edge.
    task automatic step(input logic v, input logic [15:0] w, input logic r);
        a_vld = v;
        a     = w;
        b_rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (exp_q.size() != 0 || b_vld); i++) step(1'b0, 16'h0, 1'b1);
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b0);
    endtask

    // Scoreboard monitor: every accepted byte must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && b_vld && b_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte actual=%h required=none at %0t", b, $time);
            end else begin
                check("byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        a_vld    = 1'b0;
        a        = 16'h0;
        b_rdy    = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset with a_vld asserted stores nothing
        step(1'b1, 16'hFFFF, 1'b1);
        step(1'b1, 16'hFFFF, 1'b1);
        check("rst_b_vld", b_vld, 0);
        check("rst_b",     b,     0);
        check("rst_full",  full,  0);
        check("rst_ovf",   ovf,   0);
        rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        check("rst_nothing_stored", b_vld, 0);

        // 2: single word, one-cycle latency, MSB first
        push_word(16'hA55A);
        step(1'b1, 16'hA55A, 1'b1);
        check("t2_vld",  b_vld, 1);
        check("t2_b0",   b,     8'hA5);
        step(1'b0, 16'h0, 1'b1);
        check("t2_b1",   b,     8'h5A);
        step(1'b0, 16'h0, 1'b1);
        check("t2_idle", b_vld, 0);
        check("t2_idle_b", b,   0);

        // 3: backpressure holds byte stable, then gap-free release
        push_word(16'h1234);
        push_word(16'h5678);
        step(1'b1, 16'h1234, 1'b0);
        step(1'b1, 16'h5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_b", b, 8'h12);
            step(1'b0, 16'h0, 1'b0);
        end
        check("t3_hold_vld", b_vld, 1);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
        check("t3_no_gaps", exp_q.size(), 0);
        check("t3_ovf", ovf, 0);
        check("t3_empty", b_vld, 0);

        // 4: overflow drops 5th word, ovf sticky
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        push_word(16'h4444);
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        step(1'b1, 16'h3333, 1'b0);
        check("t4_not_full3", full, 0);
        step(1'b1, 16'h4444, 1'b0);
        check("t4_full", full, 1);
        check("t4_ovf_before", ovf, 0);
        step(1'b1, 16'h5555, 1'b0);
        check("t4_ovf", ovf, 1);
        check("t4_full_after_drop", full, 1);
        drain("t4_drain");
        check("t4_ovf_sticky", ovf, 1);
        check("t4_full_cleared", full, 0);

        // 5: full with pop and write in the same cycle
        do_reset();
        check("t5_ovf_reset", ovf, 0);
        push_word(16'hAA01);
        push_word(16'hBB02);
        push_word(16'hCC03);
        push_word(16'hDD04);
        step(1'b1, 16'hAA01, 1'b0);
        step(1'b1, 16'hBB02, 1'b0);
        step(1'b1, 16'hCC03, 1'b0);
        step(1'b1, 16'hDD04, 1'b0);
        check("t5_full", full, 1);
        step(1'b0, 16'h0, 1'b1);
        check("t5_last_byte", b, 8'h01);
        push_word(16'hEE05);
        step(1'b1, 16'hEE05, 1'b1);
        check("t5_ovf", ovf, 0);
        check("t5_full_kept", full, 1);
        check("t5_next_head", b, 8'hBB);
        drain("t5_drain");

        // 6: reset mid-word discards remaining byte
        exp_q.push_back(8'hA5);
        step(1'b1, 16'hA55A, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        check("t6_pre_b", b, 8'h5A);
        rst_n = 1'b0;
        #1;
        check("t6_async_vld", b_vld, 0);
        check("t6_async_b",   b,     0);
        step(1'b0, 16'h0, 1'b1);
        rst_n = 1'b1;
        step(1'b0, 16'h0, 1'b1);
        check("t6_no_5a", b_vld, 0);
        push_word(16'hC33C);
        step(1'b1, 16'hC33C, 1'b1);
        check("t6_msb_first", b, 8'hC3);
        drain("t6_drain");

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
